// File: rtl/sent_pkg.sv
// -----------------------------------------------------------------------------
// sent_pkg
// Shared constants, FSM state type and CRC step helper for the SENT (SAE J2716)
// transmit path. The CRC helper is also intended for the receive side.
// -----------------------------------------------------------------------------
package sent_pkg;

    localparam int         SYNC_TICKS  = 56;
    localparam int         LOW_TICKS   = 5;
    localparam int         NIBBLE_BASE = 12;
    localparam logic [3:0] CRC_SEED    = 4'h5;
    localparam logic [3:0] CRC_POLY    = 4'hD;
    localparam int         MIN_PAUSE   = 12;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        STATUS,
        DATA,
        CRC,
        PAUSE
    } sent_tx_state_t;

    // One bit of the SENT CRC4: the new bit enters at the LSB, the bit that
    // falls out of the MSB folds the reduction constant back in.
    function automatic logic [3:0] crc4_bit(input logic [3:0] crc, input logic b);
        return {crc[2:0], b} ^ (crc[3] ? CRC_POLY : 4'h0);
    endfunction

endpackage

// File: rtl/sent_tx_crc4.sv
// -----------------------------------------------------------------------------
// sent_tx_crc4
// Combinational SENT CRC4 over NIBBLES data nibbles (MSB first) followed by one
// augmenting zero nibble, seeded with CRC_SEED.
//   data : 4*NIBBLES data nibbles, first-transmitted nibble in the top bits
//   crc  : resulting CRC nibble
// -----------------------------------------------------------------------------
module sent_tx_crc4
    import sent_pkg::*;
#(
    parameter int NIBBLES = 6
) (
    input  logic [4*NIBBLES-1:0] data,
    output logic [3:0]           crc
);

    logic [3:0] acc;

    always_comb begin
        acc = CRC_SEED;
        for (int i = 4*NIBBLES-1; i >= 0; i--) begin
            acc = crc4_bit(acc, data[i]);
        end
        for (int i = 0; i < 4; i++) begin
            acc = crc4_bit(acc, 1'b0);
        end
        crc = acc;
    end

endmodule

// File: rtl/sent_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sent_tx_frame_ctrl
// SENT transmit frame sequencer. A one-deep holding register takes a frame over
// a valid/ready handshake; its CRC is formed combinationally while it waits.
// On a tick the held frame is moved into the transmit registers and the line is
// sequenced through SYNC, STATUS, DATA x NIBBLES, CRC and an optional PAUSE.
// Every segment is 5 ticks low followed by high for the rest of its length.
//   clk_tx       : transmit clock
//   reset_tx     : synchronous active-high reset
//   tick_en      : one-cycle strobe per SENT unit time
//   frame_valid  : frame offered
//   frame_ready  : holding register empty
//   frame_status : status/comm nibble
//   frame_data   : data nibbles, first-transmitted nibble in the top bits
//   sent_out     : SENT line (idles high)
//   busy         : frame in transmission
//   frame_done   : one-cycle pulse on the edge that ends a frame
// -----------------------------------------------------------------------------
module sent_tx_frame_ctrl
    import sent_pkg::*;
#(
    parameter int NIBBLES     = 6,
    parameter int FRAME_TICKS = 0
) (
    input  logic                 clk_tx,
    input  logic                 reset_tx,
    input  logic                 tick_en,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [3:0]           frame_status,
    input  logic [4*NIBBLES-1:0] frame_data,
    output logic                 sent_out,
    output logic                 busy,
    output logic                 frame_done
);

    // Counters must hold the longest non-pause frame (56 + 8*27 = 272) and the
    // full configured frame length.
    localparam int CNT_W = (FRAME_TICKS > 511) ? $clog2(FRAME_TICKS + 1) : 9;
    localparam int IDX_W = $clog2(NIBBLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYNC_LEN = CNT_W'(SYNC_TICKS);
    localparam logic [CNT_W-1:0] LOW_LEN  = CNT_W'(LOW_TICKS);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES);

    sent_tx_state_t       state, state_n;
    logic [CNT_W-1:0]     seg_cnt, seg_cnt_n;
    logic [CNT_W-1:0]     seg_len, seg_len_n;
    logic [CNT_W-1:0]     frame_cnt, frame_cnt_n;
    logic [IDX_W-1:0]     nib_idx, nib_idx_n;
    logic                 sent_out_n;
    logic                 done_n;
    logic                 hold_valid;
    logic                 accept;
    logic                 load_tx;
    logic                 shift_data;
    logic                 start_sync;
    logic                 end_frame;

    logic [3:0]           hold_status;
    logic [4*NIBBLES-1:0] hold_data;
    logic [3:0]           hold_crc;
    logic [3:0]           tx_status;
    logic [4*NIBBLES-1:0] tx_data;
    logic [3:0]           tx_crc;

    function automatic logic [CNT_W-1:0] nibble_len(input logic [3:0] v);
        return CNT_W'(NIBBLE_BASE) + CNT_W'(v);
    endfunction

    // Pause fills the frame up to FRAME_TICKS but never drops below MIN_PAUSE.
    function automatic logic [CNT_W-1:0] pause_len(input logic [CNT_W-1:0] used);
        logic [CNT_W:0] need;
        need = {1'b0, used} + (CNT_W+1)'(MIN_PAUSE);
        if (need > (CNT_W+1)'(FRAME_TICKS)) begin
            return CNT_W'(MIN_PAUSE);
        end
        return CNT_W'(FRAME_TICKS) - used;
    endfunction

    assign accept      = frame_valid && !hold_valid;
    assign frame_ready = !hold_valid;
    assign busy        = (state != IDLE);

    // ---- holding stage: CRC formed while the frame waits for its SYNC tick ----
    sent_tx_crc4 #(
        .NIBBLES(NIBBLES)
    ) u_crc (
        .data(hold_data),
        .crc (hold_crc)
    );

    always_comb begin
        state_n     = state;
        seg_cnt_n   = seg_cnt;
        seg_len_n   = seg_len;
        frame_cnt_n = frame_cnt;
        nib_idx_n   = nib_idx;
        sent_out_n  = sent_out;
        done_n      = 1'b0;
        load_tx     = 1'b0;
        shift_data  = 1'b0;
        start_sync  = 1'b0;
        end_frame   = 1'b0;

        if (tick_en) begin
            if (state == IDLE) begin
                start_sync = hold_valid;
            end else if (seg_cnt != seg_len) begin
                seg_cnt_n   = seg_cnt + CNT_ONE;
                frame_cnt_n = frame_cnt + CNT_ONE;
                if (seg_cnt >= LOW_LEN) begin
                    sent_out_n = 1'b1;
                end
            end else begin
                // This tick is the first one of the following segment.
                seg_cnt_n   = CNT_ONE;
                frame_cnt_n = frame_cnt + CNT_ONE;
                sent_out_n  = 1'b0;
                case (state)
                    SYNC: begin
                        state_n   = STATUS;
                        seg_len_n = nibble_len(tx_status);
                    end
                    STATUS: begin
                        state_n    = DATA;
                        seg_len_n  = nibble_len(tx_data[4*NIBBLES-1 -: 4]);
                        shift_data = 1'b1;
                        nib_idx_n  = IDX_ONE;
                    end
                    DATA: begin
                        if (nib_idx == IDX_LAST) begin
                            state_n   = CRC;
                            seg_len_n = nibble_len(tx_crc);
                        end else begin
                            seg_len_n  = nibble_len(tx_data[4*NIBBLES-1 -: 4]);
                            shift_data = 1'b1;
                            nib_idx_n  = nib_idx + IDX_ONE;
                        end
                    end
                    CRC: begin
                        if (FRAME_TICKS != 0) begin
                            state_n   = PAUSE;
                            seg_len_n = pause_len(frame_cnt);
                        end else begin
                            end_frame = 1'b1;
                        end
                    end
                    PAUSE: begin
                        end_frame = 1'b1;
                    end
                    default: begin
                        state_n = IDLE;
                    end
                endcase
            end
        end

        if (end_frame) begin
            done_n = 1'b1;
            if (hold_valid) begin
                start_sync = 1'b1;
            end else begin
                state_n    = IDLE;
                seg_cnt_n  = '0;
                sent_out_n = 1'b1;
            end
        end

        if (start_sync) begin
            state_n     = SYNC;
            seg_len_n   = SYNC_LEN;
            seg_cnt_n   = CNT_ONE;
            frame_cnt_n = CNT_ONE;
            nib_idx_n   = '0;
            sent_out_n  = 1'b0;
            load_tx     = 1'b1;
        end
    end

    // ---- control registers ----
    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            state      <= IDLE;
            seg_cnt    <= '0;
            seg_len    <= '0;
            frame_cnt  <= '0;
            nib_idx    <= '0;
            sent_out   <= 1'b1;
            frame_done <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            state      <= state_n;
            seg_cnt    <= seg_cnt_n;
            seg_len    <= seg_len_n;
            frame_cnt  <= frame_cnt_n;
            nib_idx    <= nib_idx_n;
            sent_out   <= sent_out_n;
            frame_done <= done_n;
            if (load_tx) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
            end
        end
    end

    // ---- data registers: holding stage and transmit shift register ----
    always_ff @(posedge clk_tx) begin
        if (accept) begin
            hold_status <= frame_status;
            hold_data   <= frame_data;
        end
        if (load_tx) begin
            tx_status <= hold_status;
            tx_data   <= hold_data;
            tx_crc    <= hold_crc;
        end else if (shift_data) begin
            tx_data <= tx_data << 4;
        end
    end

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sent_tx_frame_ctrl
// Three instances share stimulus: FRAME_TICKS = 0, 282 and 200. A monitor logs
// the tick index of every sent_out fall/rise and frame_done pulse; frames are
// then checked segment by segment against expected lengths.
// -----------------------------------------------------------------------------
module tb_sent_tx_frame_ctrl;

    typedef struct {
        logic [3:0]  st;
        logic [23:0] dat;
        logic [3:0]  crc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_tx;
    logic        tick_en = 1'b0;
    logic [2:0]  frame_valid;
    logic [3:0]  frame_status;
    logic [23:0] frame_data;
    logic [2:0]  frame_ready;
    logic [2:0]  sent_out;
    logic [2:0]  busy;
    logic [2:0]  frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt = 0;

    int falls [3][32];
    int rises [3][32];
    int dones [3][8];
    int nfalls[3];
    int nrises[3];
    int ndones[3];
    int nbfall[3];
    logic [2:0] prev_out  = 3'b111;
    logic [2:0] prev_busy = 3'b000;

    int   ft_of[3];
    vec_t vecs[5];

    always #5 clk = ~clk;

    sent_tx_frame_ctrl #(.NIBBLES(6), .FRAME_TICKS(0)) u0 (
        .clk_tx(clk), .reset_tx(reset_tx), .tick_en(tick_en),
        .frame_valid(frame_valid[0]), .frame_ready(frame_ready[0]),
        .frame_status(frame_status), .frame_data(frame_data),
        .sent_out(sent_out[0]), .busy(busy[0]), .frame_done(frame_done[0]));

    sent_tx_frame_ctrl #(.NIBBLES(6), .FRAME_TICKS(282)) u1 (
        .clk_tx(clk), .reset_tx(reset_tx), .tick_en(tick_en),
        .frame_valid(frame_valid[1]), .frame_ready(frame_ready[1]),
        .frame_status(frame_status), .frame_data(frame_data),
        .sent_out(sent_out[1]), .busy(busy[1]), .frame_done(frame_done[1]));

    sent_tx_frame_ctrl #(.NIBBLES(6), .FRAME_TICKS(200)) u2 (
        .clk_tx(clk), .reset_tx(reset_tx), .tick_en(tick_en),
        .frame_valid(frame_valid[2]), .frame_ready(frame_ready[2]),
        .frame_status(frame_status), .frame_data(frame_data),
        .sent_out(sent_out[2]), .busy(busy[2]), .frame_done(frame_done[2]));

    // Tick strobe every 4 cycles.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_en = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    always @(posedge clk) begin
        if (tick_en) tick_cnt <= tick_cnt + 1;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (prev_out[d] === 1'b1 && sent_out[d] === 1'b0) begin
                if (nfalls[d] < 32) falls[d][nfalls[d]] = tick_cnt;
                nfalls[d]++;
            end
            if (prev_out[d] === 1'b0 && sent_out[d] === 1'b1) begin
                if (nrises[d] < 32) rises[d][nrises[d]] = tick_cnt;
                nrises[d]++;
            end
            if (frame_done[d] === 1'b1) begin
                if (ndones[d] < 8) dones[d][ndones[d]] = tick_cnt;
                ndones[d]++;
            end
            if (prev_busy[d] === 1'b1 && busy[d] === 1'b0) nbfall[d]++;
            prev_out[d]  = sent_out[d];
            prev_busy[d] = busy[d];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        for (int d = 0; d < 3; d++) begin
            nfalls[d] = 0;
            nrises[d] = 0;
            ndones[d] = 0;
            nbfall[d] = 0;
        end
    endtask

    function automatic logic [3:0] ref_crc(input logic [23:0] d);
        logic [3:0] c;
        c = 4'h5;
        for (int i = 23; i >= 0; i--) c = {c[2:0], d[i]} ^ (c[3] ? 4'hD : 4'h0);
        for (int i = 0; i < 4; i++) c = {c[2:0], 1'b0} ^ (c[3] ? 4'hD : 4'h0);
        return c;
    endfunction

    // idx: 0 sync, 1 status, 2..7 data nibbles, 8 crc, 9 pause
    function automatic int seg_model(input int ft, input int idx, input logic [3:0] st,
                                     input logic [23:0] dat, input logic [3:0] crc);
        int used;
        case (idx)
            0: return 56;
            1: return 12 + int'(st);
            8: return 12 + int'(crc);
            9: begin
                used = 56 + 12 + int'(st) + 12 + int'(crc);
                for (int k = 0; k < 6; k++) used += 12 + int'(dat[4*(5-k) +: 4]);
                return (ft - used < 12) ? 12 : ft - used;
            end
            default: return 12 + int'(dat[4*(7-idx) +: 4]);
        endcase
    endfunction

    task automatic check_frame(input int d, input int ft, input logic [3:0] st,
                               input logic [23:0] dat, input logic [3:0] crc,
                               input int base, input int didx);
        int nseg, total, e;
        nseg  = (ft != 0) ? 10 : 9;
        total = 0;
        check($sformatf("dut%0d pulses_seen", d),
              (nfalls[d] >= base + nseg && nrises[d] >= base + nseg && ndones[d] > didx) ? 1 : 0, 1);
        if (nfalls[d] >= base + nseg && nrises[d] >= base + nseg && ndones[d] > didx &&
            base + nseg <= 32) begin
            for (int i = 0; i < nseg; i++) begin
                e = seg_model(ft, i, st, dat, crc);
                total += e;
                if (i < nseg - 1)
                    check($sformatf("dut%0d seg%0d_len", d, i),
                          falls[d][base+i+1] - falls[d][base+i], e);
                check($sformatf("dut%0d seg%0d_low", d, i),
                      rises[d][base+i] - falls[d][base+i], 5);
            end
            check($sformatf("dut%0d frame_len", d), dones[d][didx] - falls[d][base], total);
        end
    endtask

    task automatic wait_done(input logic [2:0] mask, input int cnt);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 6000 && !ok; c++) begin
            @(negedge clk);
            ok = 1'b1;
            for (int d = 0; d < 3; d++) if (mask[d] && ndones[d] < cnt) ok = 1'b0;
        end
        check("done_wait", ok, 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic offer(input logic [2:0] mask, input logic [3:0] st,
                         input logic [23:0] dat, output int hs_tick);
        logic [2:0] acc;
        hs_tick = -1;
        @(posedge clk);
        #1;
        frame_status = st;
        frame_data   = dat;
        frame_valid  = mask;
        for (int c = 0; c < 200 && frame_valid != 3'b000; c++) begin
            @(negedge clk);
            acc = frame_valid & frame_ready;
            @(posedge clk);
            #1;
            frame_valid = frame_valid & ~acc;
            if (acc != 3'b000) hs_tick = tick_cnt;
        end
        check("handshake", int'(frame_valid), 0);
    endtask

    task automatic run_all(input logic [3:0] st, input logic [23:0] dat, input logic [3:0] crc);
        int hs;
        clear_mon();
        offer(3'b111, st, dat, hs);
        wait_done(3'b111, 1);
        for (int d = 0; d < 3; d++) begin
            check_frame(d, ft_of[d], st, dat, crc, 0, 0);
            check($sformatf("dut%0d done_count", d), ndones[d], 1);
            check($sformatf("dut%0d busy_falls", d), nbfall[d], 1);
            check($sformatf("dut%0d line_idle", d), int'(sent_out[d]), 1);
            check($sformatf("dut%0d busy_idle", d), int'(busy[d]), 0);
        end
    endtask

    initial begin
        int hs1, hs2;
        bit seen;
        logic [3:0]  rst_st;
        logic [23:0] rst_dat;

        ft_of[0] = 0;
        ft_of[1] = 282;
        ft_of[2] = 200;
        vecs[0] = '{st: 4'h0, dat: 24'h000000, crc: 4'h5};
        vecs[1] = '{st: 4'hF, dat: 24'hFFFFFF, crc: 4'hA};
        vecs[2] = '{st: 4'h1, dat: 24'h000001, crc: 4'h8};
        vecs[3] = '{st: 4'h3, dat: 24'h123456, crc: 4'h2};
        vecs[4] = '{st: 4'h9, dat: 24'hA5C30F, crc: 4'hC};

        clear_mon();
        reset_tx     = 1'b1;
        frame_valid  = 3'b000;
        frame_status = 4'h0;
        frame_data   = 24'h0;
        repeat (3) @(posedge clk);
        #1 reset_tx = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d rst_sent_out", d), int'(sent_out[d]), 1);
            check($sformatf("dut%0d rst_busy", d), int'(busy[d]), 0);
            check($sformatf("dut%0d rst_done", d), int'(frame_done[d]), 0);
            check($sformatf("dut%0d rst_ready", d), int'(frame_ready[d]), 1);
        end

        // Ticks with nothing held must not disturb the line.
        clear_mon();
        repeat (60) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d idle_falls", d), nfalls[d], 0);
            check($sformatf("dut%0d idle_busy", d), int'(busy[d]), 0);
        end

        for (int i = 0; i < 5; i++) run_all(vecs[i].st, vecs[i].dat, vecs[i].crc);

        for (int i = 0; i < 3; i++) begin
            logic [3:0]  rs;
            logic [23:0] rd;
            rs = 4'($urandom_range(0, 15));
            rd = 24'($urandom);
            run_all(rs, rd, ref_crc(rd));
        end

        // Back-to-back frames on the FRAME_TICKS=0 instance.
        clear_mon();
        offer(3'b001, 4'h0, 24'h000000, hs1);
        @(negedge clk);
        check("b2b ready_low", int'(frame_ready[0]), 0);
        offer(3'b001, 4'h3, 24'h123456, hs2);
        check("b2b accept_at_sync", hs2, (nfalls[0] > 0) ? falls[0][0] : -1);
        wait_done(3'b001, 2);
        check("b2b done_count", ndones[0], 2);
        check("b2b falls", nfalls[0], 18);
        if (nfalls[0] >= 10 && ndones[0] >= 1)
            check("b2b sync_on_end", falls[0][9], dones[0][0]);
        check("b2b busy_falls", nbfall[0], 1);
        check_frame(0, 0, 4'h0, 24'h000000, 4'h5, 0, 0);
        check_frame(0, 0, 4'h3, 24'h123456, 4'h2, 9, 1);

        // Reset while a DATA nibble is low.
        clear_mon();
        rst_st  = 4'h3;
        rst_dat = 24'h123456;
        offer(3'b001, rst_st, rst_dat, hs1);
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            seen = (nfalls[0] >= 4);
        end
        check("rst data_reached", seen, 1);
        check("rst pre_low", int'(sent_out[0]), 0);
        @(posedge clk);
        #1 reset_tx = 1'b1;
        @(posedge clk);
        #1 reset_tx = 1'b0;
        @(negedge clk);
        check("rst sent_out", int'(sent_out[0]), 1);
        check("rst ready", int'(frame_ready[0]), 1);
        check("rst busy", int'(busy[0]), 0);
        repeat (600) @(negedge clk);
        check("rst no_done", ndones[0], 0);
        check("rst no_more_falls", nfalls[0], 4);
        run_all(4'hA, 24'hA5C30F, 4'hC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
